// File: rtl/cache_port_arbiter_if.sv
// Requester and cache-side signal bundle for cache_port_arbiter.
// slave = arbiter view, master = requesters plus cache view.
interface cache_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      err;
    logic                      busy;
    logic [ADDR_W-1:0]         cache_address;
    logic [DATA_W-1:0]         cache_data_in;
    logic                      cache_rw;
    logic [DATA_W-1:0]         cache_data_out;
    logic                      cache_ready;

    modport slave (
        input  req, req_rw, req_addr, req_wdata,
        input  cache_data_out, cache_ready,
        output gnt, done, rdata, err, busy,
        output cache_address, cache_data_in, cache_rw
    );

    modport master (
        output req, req_rw, req_addr, req_wdata,
        output cache_data_out, cache_ready,
        input  gnt, done, rdata, err, busy,
        input  cache_address, cache_data_in, cache_rw
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache_controller port among NUM_REQ requesters.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module cache_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
`ifdef ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 255
`endif
) (
    input logic                 clk,
    input logic                 rst,
    cache_port_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, FLUSH, WAIT} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       id_q, id_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rw_q, rw_d;

    logic                found;
    logic [IW-1:0]       cand;
    logic [IW-1:0]       sel;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_rw;
    logic [IW-1:0]       nxt_ptr;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found     = 1'b0;
        cand      = '0;
        sel       = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rw    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found     = 1'b1;
                sel       = cand;
                sel_addr  = bus.req_addr[cand*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[cand*DATA_W +: DATA_W];
                sel_rw    = bus.req_rw[cand];
            end
        end
    end

    assign nxt_ptr = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
`ifdef ARB_TIMEOUT_EN
        err_d    = 1'b0;
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                addr_d = '0;
                rw_d   = 1'b0;
                if (found) begin
                    id_d       = sel;
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    busy_d     = 1'b1;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    rw_d       = sel_rw;
                    state_d    = FLUSH;
                end
            end
            // First ready after grant may belong to a stale access.
            FLUSH: begin
                if (bus.cache_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.cache_ready) begin
                    state_d  = IDLE;
                    rdata_d  = bus.cache_data_out;
                    done_d   = gnt_q;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = nxt_ptr;
                    rw_d     = 1'b0;
                    addr_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef ARB_TIMEOUT_EN
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(TIMEOUT_CYC - 1) &&
                !(state_q == WAIT && bus.cache_ready)) begin
                state_d  = IDLE;
                done_d   = gnt_q;
                err_d    = 1'b1;
                gnt_d    = '0;
                busy_d   = 1'b0;
                rr_ptr_d = nxt_ptr;
                rw_d     = 1'b0;
                addr_d   = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.done          = done_q;
    assign bus.rdata         = rdata_q;
    assign bus.busy          = busy_q;
    assign bus.cache_address = addr_q;
    assign bus.cache_data_in = wdata_q;
    assign bus.cache_rw      = rw_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.err           = err_q;
`else
    assign bus.err           = 1'b0;
`endif
endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares one cache_controller port among NUM_REQ requesters (e.g. I-fetch, load/store, DMA, debug) using round-robin arbitration.
- Each requester uses a req/done handshake. The block drives the cache's address/data_in/rw inputs and collects data_out on the cache ready pulse.
- The cache has no request-valid input and restarts an access whenever it is idle. The arbiter therefore discards the first ready after a grant (flush) and accepts the second.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request; address/rw/wdata must be held stable while req=1 and done=0
- req_rw  in  NUM_REQ  0=read, 1=write
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rdata  out  DATA_W  read data, valid in the done cycle, held until the next done
- err  out  1  timeout flag, valid with done
- busy  out  1  transaction in progress
- cache_address  out  ADDR_W  to cache address
- cache_data_in  out  DATA_W  to cache data_in
- cache_rw  out  1  to cache rw
- cache_data_out  in  DATA_W  from cache data_out
- cache_ready  in  1  from cache ready (one-cycle pulse)

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, gnt=0, done=0, rdata=0, err=0, busy=0, cache_address=0, cache_data_in=0, cache_rw=0.
- All outputs are registered.
- IDLE
  - Drives cache_rw=0 and cache_address=0 so background cache accesses are harmless reads.
  - If any req is high, selects the first requester at or after rr_ptr (modulo NUM_REQ).
  - Latches that requester's addr/rw/wdata into internal registers and onto the cache_* outputs.
  - Sets gnt one-hot and busy=1, then moves to FLUSH.
  - No req: stays in IDLE.
- FLUSH
  - Holds the cache_* outputs.
  - On cache_ready=1, moves to WAIT. This ready may belong to an access launched before the new inputs were stable, so it is ignored.
- WAIT
  - On cache_ready=1: rdata <= cache_data_out, done[id]=1 for one cycle, gnt=0, busy=0, rr_ptr <= (id+1) mod NUM_REQ, cache_rw <= 0, then returns to IDLE.
  - done is asserted in the cycle after the edge that sampled cache_ready.
- Writes may be applied to the cache twice (flush access and accepted access). This is acceptable because the same word and data are written (idempotent). rdata is undefined-but-stable for writes (cache echo).
- The earliest new grant is the cycle after done. A requester that keeps req high re-enters arbitration behind the others.
- If req drops mid-transaction, it is ignored; the transaction completes and done still pulses.
- Changes to inputs of the granted requester mid-transaction have no effect, because the request is latched at grant.
- Simultaneous requests are served strictly round-robin. No requester waits more than NUM_REQ-1 transactions.
- cache_ready while in IDLE is ignored.
- rst asserted mid-transaction aborts it immediately: no done is issued, and all outputs take their reset values.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears at grant and counts in FLUSH and WAIT.
  - On reaching TIMEOUT_CYC without the accepting ready: done[id]=1, err=1, rdata unchanged, rr_ptr advances, return to IDLE.
  - err is 0 on normal completions.
- Undefined: no counter; err is tied 0; the block waits indefinitely for cache_ready.

Test Plan:
- Single read: req[0]=1, addr=0x0000_1000, cache model pulses ready twice with data_out=0x0000_1000 on the second -> gnt=4'b0001 from cycle after req; done[0] one cycle after the second ready; rdata=0x0000_1000; cache_rw=0 throughout.
- Write: req[2]=1, rw=1, addr=0x40, wdata=0xCAFE_F00D -> cache_address=0x40, cache_data_in=0xCAFE_F00D, cache_rw=1 until done[2]; cache_rw returns to 0 after.
- Fairness: req=4'b1111 held continuously -> done order 0,1,2,3,0,1 with no repeats; gnt always one-hot.
- Request drop: req[1] deasserted in FLUSH -> transaction still completes with done[1]=1; no grant to 1 afterwards until it re-requests.
- Reset mid-WAIT: rst=0 for 1 cycle -> gnt=0, busy=0, no done pulse; next req[3] wins (rr_ptr=0 scan finds 3).
- ARB_TIMEOUT_EN, TIMEOUT_CYC=16: cache never pulses ready -> done[0]=1 and err=1 exactly 16 cycles after grant; next transaction completes with err=0.
